// File: rtl/mac_unit.sv
// Unsigned multiply-accumulate: z accumulates a*b on every clock edge.
// The overflow policy is a parameter: wrap modulo 2^ACC_WIDTH, or clamp at full scale.
module mac_unit #(
    parameter int A_WIDTH   = 3,
    parameter int B_WIDTH   = 3,
    parameter int ACC_WIDTH = 6,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic [ACC_WIDTH-1:0] z
);

    localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int SUM_WIDTH = ((ACC_WIDTH > P_WIDTH) ? ACC_WIDTH : P_WIDTH) + 1;

    logic [P_WIDTH-1:0]   product;
    logic [SUM_WIDTH-1:0] sum_full;
    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] acc_next;

    assign product = P_WIDTH'(a) * P_WIDTH'(b);

    // The extra top bit keeps the true sum, so a carry out of the accumulator is never lost.
    assign sum_full = SUM_WIDTH'(acc_reg) + SUM_WIDTH'(product);

    generate
        if (SATURATE) begin : g_sat
            localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
            always_comb begin
                acc_next = sum_full[ACC_WIDTH-1:0];
                if (sum_full > SUM_WIDTH'(ACC_MAX)) begin
                    acc_next = ACC_MAX;
                end
            end
        end else begin : g_wrap
            always_comb begin
                acc_next = sum_full[ACC_WIDTH-1:0];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign z = acc_reg;

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: the same stimulus is driven into a wrapping instance
// and a saturating instance, and each is compared against its own reference model.
`timescale 1ns/1ps
module tb_mac_unit;

    localparam int AW  = 3;
    localparam int BW  = 3;
    localparam int ZW  = 6;
    localparam int ZMAX = (1 << ZW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [ZW-1:0] z_wrap;
    logic [ZW-1:0] z_sat;

    int errors = 0;
    int checks = 0;
    int model_wrap = 0;
    int model_sat  = 0;
    int q_wrap[$];
    int q_sat[$];

    always #5 clk = ~clk;

    mac_unit #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ZW), .SATURATE(1'b0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .z   (z_wrap)
    );

    mac_unit #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ZW), .SATURATE(1'b1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .z   (z_sat)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one edge's worth of stimulus, predict both accumulators, then compare after the edge.
    task automatic mac_step(input bit r, input int av, input int bv);
        int exp_w;
        int exp_s;
        @(negedge clk);
        rst = r;
        a   = AW'(av);
        b   = BW'(bv);
        if (r) begin
            model_wrap = 0;
            model_sat  = 0;
        end else begin
            model_wrap = (model_wrap + av * bv) % (ZMAX + 1);
            model_sat  = model_sat + av * bv;
            if (model_sat > ZMAX) model_sat = ZMAX;
        end
        q_wrap.push_back(model_wrap);
        q_sat.push_back(model_sat);
        @(posedge clk);
        #1;
        if (q_wrap.size() == 0 || q_sat.size() == 0) begin
            check_eq("scoreboard_empty", 1, 0);
        end else begin
            exp_w = q_wrap.pop_front();
            exp_s = q_sat.pop_front();
            $display("tx rst=%0b a=%0d b=%0d z_wrap=%0d (exp %0d) z_sat=%0d (exp %0d)",
                     r, av, bv, z_wrap, exp_w, z_sat, exp_s);
            check_eq("z_wrap", int'(z_wrap), exp_w);
            check_eq("z_sat", int'(z_sat), exp_s);
        end
    endtask

    task automatic repeat_step(input int n, input int av, input int bv);
        for (int i = 0; i < n; i++) mac_step(1'b0, av, bv);
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;

        // Reset with nonzero operands, then idle with zero operands.
        mac_step(1'b1, 5, 3);
        mac_step(1'b1, 5, 3);
        repeat_step(2, 0, 0);

        // Accumulation sequence through the wrap point (43, 59, 11 on the wrapping unit).
        repeat_step(3, 1, 1);
        repeat_step(3, 2, 1);
        repeat_step(3, 3, 2);
        repeat_step(3, 4, 4);
        check_eq("wrap_at_75", int'(z_wrap), 11);
        check_eq("sat_hold_max", int'(z_sat), ZMAX);
        repeat_step(3, 5, 2);
        check_eq("wrap_after_seq", int'(z_wrap), 41);

        // Reset in the middle of a run discards the product at that edge.
        mac_step(1'b1, 0, 0);
        repeat_step(3, 3, 3);
        check_eq("pre_reset_27", int'(z_wrap), 27);
        mac_step(1'b1, 6, 1);
        repeat_step(2, 6, 1);
        check_eq("resume_12", int'(z_wrap), 12);

        // Wrap boundary: 63 + 1 -> 0, and 20 + 49 -> 5.
        mac_step(1'b1, 0, 0);
        mac_step(1'b0, 7, 7);
        mac_step(1'b0, 7, 2);
        check_eq("at_63", int'(z_wrap), 63);
        mac_step(1'b0, 1, 1);
        check_eq("wrap_63_to_0", int'(z_wrap), 0);
        mac_step(1'b1, 0, 0);
        mac_step(1'b0, 4, 5);
        mac_step(1'b0, 7, 7);
        check_eq("wrap_20_plus_49", int'(z_wrap), 5);

        // Saturation: 49, then clamp at 63, then hold, then reset clears.
        mac_step(1'b1, 0, 0);
        mac_step(1'b0, 7, 7);
        check_eq("sat_49", int'(z_sat), 49);
        mac_step(1'b0, 7, 7);
        check_eq("sat_clamp", int'(z_sat), ZMAX);
        mac_step(1'b0, 1, 1);
        check_eq("sat_stays", int'(z_sat), ZMAX);
        mac_step(1'b1, 7, 7);
        check_eq("sat_reset", int'(z_sat), 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 60; i++) begin
            mac_step(($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        check_eq("scoreboard_drained", q_wrap.size() + q_sat.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
